ddr_rd_arbiter: RTL and testbench

Four-client read arbiter that sits directly upstream of the DDR controller's read port (`ddrtop` `rd_*` user interface). It grants requesters round-robin, tags each issued read with the client index on the controller's owner field, and presents a one-deep registered request slot to the controller. Returned data is routed back to the issuing client by the owner tag. A per-client outstanding-read limit prevents any client from flooding the controller's return queue.

---
 rtl/ddr_rd_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter
// Four-client round-robin read arbiter in front of the DDR controller read
// port. Issued reads carry the client index as the owner tag. Returned data
// is steered back to the owning client. A per-client outstanding counter caps
// how many reads each client may have in flight.

module ddr_rd_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [3:0]          cl_req_i,
  input  logic [4*ADDR_W-1:0] cl_addr_i,
  output logic [3:0]          cl_ack_o,
  output logic [DATA_W-1:0]   cl_data_o,
  output logic [3:0]          cl_ready_o,
  output logic                rd_req_o,
  output logic                rd_block_o,
  output logic [1:0]          rd_owner_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic                rd_busy_i,
  input  logic [1:0]          rd_owner_i,
  input  logic [DATA_W-1:0]   rd_data_i,
  input  logic                rd_ready_i,
  output logic                err_o
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

  // Two-bit index to four-bit one-hot select.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] sel;
    case (idx)
      2'd0:    sel = 4'b0001;
      2'd1:    sel = 4'b0010;
      2'd2:    sel = 4'b0100;
      2'd3:    sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  // Request slot and return path registers.
  logic              rd_req_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [1:0]        rd_owner_r;
  logic [DATA_W-1:0] cl_data_r;
  logic [3:0]        cl_ready_r;
  logic              err_r;
  logic [1:0]        last_r;
  logic [2:0]        count_r     [4];

  // Arbitration and bookkeeping nets.
  logic              slot_free_s;
  logic [3:0]        elig_s;
  logic              grant_s;
  logic [1:0]        winner_s;
  logic [1:0]        cand_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [3:0]        inc_s;
  logic [3:0]        dec_s;
  logic [2:0]        count_nxt_s [4];
  logic              ret_err_s;

  assign rd_req_o   = rd_req_r;
  assign rd_addr_o  = rd_addr_r;
  assign rd_owner_o = rd_owner_r;
  assign rd_block_o = 1'b0;
  assign cl_data_o  = cl_data_r;
  assign cl_ready_o = cl_ready_r;
  assign err_o      = err_r;

  // The slot can take a new request when empty or when the controller is
  // accepting its current content on this edge.
  assign slot_free_s = !rd_req_r || !rd_busy_i;

  // A client is eligible while requesting and below its outstanding cap.
  always_comb begin
    elig_s = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      if (cl_req_i[n] && (count_r[n] < MAX_CNT)) begin
        elig_s[n] = 1'b1;
      end else begin
        elig_s[n] = 1'b0;
      end
    end
  end

  // Round-robin search starting at the client after the last winner.
  always_comb begin
    grant_s  = 1'b0;
    winner_s = 2'b00;
    cand_s   = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      cand_s = last_r + 2'(k);
      if (slot_free_s && !grant_s && elig_s[cand_s]) begin
        grant_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Select the winning client's address field.
  always_comb begin
    win_addr_s = {ADDR_W{1'b0}};
    case (winner_s)
      2'd0:    win_addr_s = cl_addr_i[0*ADDR_W +: ADDR_W];
      2'd1:    win_addr_s = cl_addr_i[1*ADDR_W +: ADDR_W];
      2'd2:    win_addr_s = cl_addr_i[2*ADDR_W +: ADDR_W];
      2'd3:    win_addr_s = cl_addr_i[3*ADDR_W +: ADDR_W];
      default: win_addr_s = {ADDR_W{1'b0}};
    endcase
  end

  // Acknowledge the winner in the same cycle; held low throughout reset.
  always_comb begin
    cl_ack_o = 4'b0000;
    if (!reset_i && grant_s) begin
      cl_ack_o = onehot4(winner_s);
    end else begin
      cl_ack_o = 4'b0000;
    end
  end

  // Per-client increment on capture, decrement on return (never below 0).
  always_comb begin
    inc_s = 4'b0000;
    dec_s = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      count_nxt_s[n] = count_r[n];
      inc_s[n] = grant_s && (winner_s == 2'(n));
      dec_s[n] = rd_ready_i && (rd_owner_i == 2'(n)) && (count_r[n] != 3'd0);
      case ({inc_s[n], dec_s[n]})
        2'b10:   count_nxt_s[n] = count_r[n] + 3'd1;
        2'b01:   count_nxt_s[n] = count_r[n] - 3'd1;
        default: count_nxt_s[n] = count_r[n];
      endcase
    end
  end

  // A return tagged for a client with nothing outstanding is a protocol error.
  assign ret_err_s = rd_ready_i && (count_r[rd_owner_i] == 3'd0);

  // Request slot: load on grant, drop when accepted with nothing to follow.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_req_r   <= 1'b0;
      rd_addr_r  <= {ADDR_W{1'b0}};
      rd_owner_r <= 2'b00;
      last_r     <= 2'd3;
    end else if (grant_s) begin
      rd_req_r   <= 1'b1;
      rd_addr_r  <= win_addr_s;
      rd_owner_r <= winner_s;
      last_r     <= winner_s;
    end else if (slot_free_s) begin
      rd_req_r   <= 1'b0;
    end
  end

  // Outstanding read counters per client.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int n = 0; n < 4; n++) begin
        count_r[n] <= 3'd0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        count_r[n] <= count_nxt_s[n];
      end
    end
  end

  // Return path: route controller data to the owning client for one cycle.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cl_data_r  <= {DATA_W{1'b0}};
      cl_ready_r <= 4'b0000;
    end else if (rd_ready_i) begin
      cl_data_r  <= rd_data_i;
      cl_ready_r <= onehot4(rd_owner_i);
    end else begin
      cl_ready_r <= 4'b0000;
    end
  end

  // Sticky error flag for returns with no matching outstanding read.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | ret_err_s;
    end
  end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Self-checking bench for ddr_rd_arbiter. Returned reads and expected grant
// order go through scoreboard queues; each scenario is its own task.

module tb_ddr_rd_arbiter;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;

  logic                clock;
  logic                reset_i;
  logic [3:0]          cl_req_i;
  logic [4*ADDR_W-1:0] cl_addr_i;
  logic [3:0]          cl_ack_o;
  logic [DATA_W-1:0]   cl_data_o;
  logic [3:0]          cl_ready_o;
  logic                rd_req_o;
  logic                rd_block_o;
  logic [1:0]          rd_owner_o;
  logic [ADDR_W-1:0]   rd_addr_o;
  logic                rd_busy_i;
  logic [1:0]          rd_owner_i;
  logic [DATA_W-1:0]   rd_data_i;
  logic                rd_ready_i;
  logic                err_o;

  typedef struct {
    logic [1:0]        owner;
    logic [DATA_W-1:0] data;
  } ret_t;

  ret_t       ret_q[$];
  logic [1:0] grant_q[$];
  int         checks = 0;
  int         errors = 0;

  ddr_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(4)) dut (
    .clock_i    (clock),
    .reset_i    (reset_i),
    .cl_req_i   (cl_req_i),
    .cl_addr_i  (cl_addr_i),
    .cl_ack_o   (cl_ack_o),
    .cl_data_o  (cl_data_o),
    .cl_ready_o (cl_ready_o),
    .rd_req_o   (rd_req_o),
    .rd_block_o (rd_block_o),
    .rd_owner_o (rd_owner_o),
    .rd_addr_o  (rd_addr_o),
    .rd_busy_i  (rd_busy_i),
    .rd_owner_i (rd_owner_i),
    .rd_data_i  (rd_data_i),
    .rd_ready_i (rd_ready_i),
    .err_o      (err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_addr(input int n, input logic [ADDR_W-1:0] a);
    cl_addr_i[n*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic do_reset();
    reset_i    = 1'b1;
    cl_req_i   = 4'b0000;
    rd_busy_i  = 1'b0;
    rd_ready_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic drive_ret(input logic [1:0] owner, input logic [DATA_W-1:0] data);
    ret_t e;
    rd_ready_i = 1'b1;
    rd_owner_i = owner;
    rd_data_i  = data;
    e.owner = owner;
    e.data  = data;
    ret_q.push_back(e);
  endtask

  task automatic check_ret();
    ret_t e;
    rd_ready_i = 1'b0;
    checks++;
    if (ret_q.size() == 0) begin
      errors++;
      $display("FAIL ret_queue: got empty queue required an entry");
    end else begin
      e = ret_q.pop_front();
      if (cl_ready_o !== (4'b0001 << e.owner) || cl_data_o !== e.data) begin
        errors++;
        $display("FAIL ret_route: got ready=%b data=%h required ready=%b data=%h",
                 cl_ready_o, cl_data_o, 4'b0001 << e.owner, e.data);
      end
    end
  endtask

  task automatic test_reset();
    reset_i  = 1'b1;
    cl_req_i = 4'b1111;
    tick();
    tick();
    checks++;
    if ({rd_req_o, rd_block_o, err_o} !== 3'b000 || rd_addr_o !== '0 || rd_owner_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_slot: got req=%b blk=%b err=%b addr=%h own=%0d required all zero",
               rd_req_o, rd_block_o, err_o, rd_addr_o, rd_owner_o);
    end
    checks++;
    if (cl_ready_o !== 4'b0000 || cl_data_o !== '0 || cl_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_client: got ready=%b data=%h ack=%b required zero",
               cl_ready_o, cl_data_o, cl_ack_o);
    end
    cl_req_i = 4'b0000;
    reset_i  = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    set_addr(2, 23'd197);
    cl_req_i = 4'b0100;
    #1;
    checks++;
    if (cl_ack_o !== 4'b0100) begin
      errors++;
      $display("FAIL single_ack: got %b required 0100", cl_ack_o);
    end
    tick();
    cl_req_i = 4'b0000;
    checks++;
    if (rd_req_o !== 1'b1 || rd_addr_o !== 23'd197 || rd_owner_o !== 2'd2 || rd_block_o !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: got req=%b addr=%0d own=%0d blk=%b required 1 197 2 0",
               rd_req_o, rd_addr_o, rd_owner_o, rd_block_o);
    end
    tick();
    checks++;
    if (rd_req_o !== 1'b0) begin
      errors++;
      $display("FAIL single_drop: got rd_req=%b required 0", rd_req_o);
    end
    drive_ret(2'd2, 32'h56a3009e);
    tick();
    check_ret();
    tick();
    checks++;
    if (cl_ready_o !== 4'b0000 || cl_data_o !== 32'h56a3009e) begin
      errors++;
      $display("FAIL single_pulse: got ready=%b data=%h required 0000 56a3009e",
               cl_ready_o, cl_data_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_w;
    logic [1:0] w;
    do_reset();
    for (int n = 0; n < 4; n++) set_addr(n, 23'(1000 + n));
    cl_req_i = 4'b1111;
    exp_w = 2'd3;
    for (int i = 0; i < 8; i++) begin
      exp_w = exp_w + 2'd1;
      grant_q.push_back(exp_w);
      #1;
      checks++;
      if (cl_ack_o !== (4'b0001 << exp_w)) begin
        errors++;
        $display("FAIL rr_ack: cycle %0d got %b required %b", i, cl_ack_o, 4'b0001 << exp_w);
      end
      tick();
      w = grant_q.pop_front();
      checks++;
      if (rd_req_o !== 1'b1 || rd_owner_o !== w || rd_addr_o !== 23'(1000 + w)) begin
        errors++;
        $display("FAIL rr_issue: cycle %0d got req=%b own=%0d addr=%0d required 1 %0d %0d",
                 i, rd_req_o, rd_owner_o, rd_addr_o, w, 1000 + w);
      end
    end
    cl_req_i = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_addr(0, 23'h0001A0);
    set_addr(1, 23'h0002B0);
    cl_req_i = 4'b0011;
    #1;
    checks++;
    if (cl_ack_o !== 4'b0001) begin
      errors++;
      $display("FAIL bp_first_ack: got %b required 0001", cl_ack_o);
    end
    tick();
    cl_req_i  = 4'b0010;
    rd_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (cl_ack_o !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ack_hold: cycle %0d got %b required 0000", i, cl_ack_o);
      end
      tick();
      checks++;
      if (rd_req_o !== 1'b1 || rd_addr_o !== 23'h0001A0 || rd_owner_o !== 2'd0) begin
        errors++;
        $display("FAIL bp_slot_hold: cycle %0d got req=%b addr=%h own=%0d required 1 0001a0 0",
                 i, rd_req_o, rd_addr_o, rd_owner_o);
      end
    end
    rd_busy_i = 1'b0;
    #1;
    checks++;
    if (cl_ack_o !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_ack: got %b required 0010", cl_ack_o);
    end
    tick();
    cl_req_i = 4'b0000;
    checks++;
    if (rd_req_o !== 1'b1 || rd_addr_o !== 23'h0002B0 || rd_owner_o !== 2'd1) begin
      errors++;
      $display("FAIL bp_next_issue: got req=%b addr=%h own=%0d required 1 0002b0 1",
               rd_req_o, rd_addr_o, rd_owner_o);
    end
    tick();
    checks++;
    if (rd_req_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got rd_req=%b required 0", rd_req_o);
    end
  endtask

  task automatic test_outstanding_limit();
    logic [3:0] exp_ack;
    do_reset();
    set_addr(1, 23'h0000C8);
    cl_req_i = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      exp_ack = (i < 4) ? 4'b0010 : 4'b0000;
      #1;
      checks++;
      if (cl_ack_o !== exp_ack) begin
        errors++;
        $display("FAIL limit_ack: cycle %0d got %b required %b", i, cl_ack_o, exp_ack);
      end
      tick();
    end
    drive_ret(2'd1, 32'hA5A50001);
    #1;
    checks++;
    if (cl_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL limit_ret_cycle: got %b required 0000", cl_ack_o);
    end
    tick();
    check_ret();
    #1;
    checks++;
    if (cl_ack_o !== 4'b0010) begin
      errors++;
      $display("FAIL limit_reopen: got %b required 0010", cl_ack_o);
    end
    tick();
    #1;
    checks++;
    if (cl_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL limit_reclose: got %b required 0000", cl_ack_o);
    end
    cl_req_i = 4'b0000;
    tick();
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_ack;
    do_reset();
    set_addr(0, 23'h000040);
    cl_req_i = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (cl_ack_o !== 4'b0001) begin
        errors++;
        $display("FAIL sim_fill_ack: cycle %0d got %b required 0001", i, cl_ack_o);
      end
      tick();
    end
    drive_ret(2'd0, 32'h12345678);
    #1;
    checks++;
    if (cl_ack_o !== 4'b0001) begin
      errors++;
      $display("FAIL sim_both_ack: got %b required 0001", cl_ack_o);
    end
    tick();
    check_ret();
    for (int i = 0; i < 4; i++) begin
      exp_ack = (i < 2) ? 4'b0001 : 4'b0000;
      #1;
      checks++;
      if (cl_ack_o !== exp_ack) begin
        errors++;
        $display("FAIL sim_count_kept: cycle %0d got %b required %b", i, cl_ack_o, exp_ack);
      end
      tick();
    end
    cl_req_i = 4'b0000;
  endtask

  task automatic test_spurious();
    do_reset();
    drive_ret(2'd3, 32'hDEADBEEF);
    tick();
    check_ret();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (err_o !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky: cycle %0d got %b required 1", i, err_o);
      end
      tick();
    end
    set_addr(2, 23'h000007);
    cl_req_i  = 4'b0100;
    rd_busy_i = 1'b1;
    tick();
    checks++;
    if (rd_req_o !== 1'b1 || rd_owner_o !== 2'd2) begin
      errors++;
      $display("FAIL err_slot_load: got req=%b own=%0d required 1 2", rd_req_o, rd_owner_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (err_o !== 1'b0 || rd_req_o !== 1'b0 || rd_addr_o !== '0 || rd_owner_o !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_slot: got err=%b req=%b addr=%h own=%0d required zero",
               err_o, rd_req_o, rd_addr_o, rd_owner_o);
    end
    checks++;
    if (cl_ready_o !== 4'b0000 || cl_data_o !== '0 || cl_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_client: got ready=%b data=%h ack=%b required zero",
               cl_ready_o, cl_data_o, cl_ack_o);
    end
    cl_req_i  = 4'b0000;
    rd_busy_i = 1'b0;
    tick();
    reset_i = 1'b0;
    drive_ret(2'd0, 32'h0BAD0000);
    tick();
    check_ret();
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_after_reset: got %b required 1", err_o);
    end
  endtask

  initial begin
    reset_i    = 1'b1;
    cl_req_i   = 4'b0000;
    cl_addr_i  = '0;
    rd_busy_i  = 1'b0;
    rd_owner_i = 2'b00;
    rd_data_i  = '0;
    rd_ready_i = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_outstanding_limit();
    test_simultaneous();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
